// File: rtl/wrf_frame_checker.sv
// Receive-side checker for the 16-bit pipelined-Wishbone WR fabric: verifies dst MAC, ethertype
// and the sequential-byte payload of each frame. Optional random sink stall: WRF_FRAME_CHECKER_RAND_STALL_EN.
module wrf_frame_checker #(
  parameter logic [15:0] g_ethertype = 16'h88F7,
  parameter int unsigned g_max_len   = 1522,
  parameter logic [15:0] g_seed      = 16'hACE1
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic        snk_we_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [15:0] snk_dat_i,
  input  logic [1:0]  snk_sel_i,
  output logic        snk_stall_o,
  output logic        snk_ack_o,
  output logic        snk_err_o,
  input  logic [47:0] cfg_dst_i,
  input  logic        clr_i,
  output logic        done_o,
  output logic        ok_o,
  output logic [15:0] len_o,
  output logic [4:0]  flags_o,
  output logic [31:0] cnt_good_o,
  output logic [31:0] cnt_bad_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  localparam int F_RUNT = 0, F_DST = 1, F_TYPE = 2, F_PAY = 3, F_OVER = 4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  widx_q, widx_d;
  logic [15:0] bytes_q, bytes_d;
  logic [7:0]  pat_q, pat_d;
  logic [4:0]  flags_q, flags_d;
  logic        ack_q, err_q, done_q, ok_q;
  logic [15:0] len_q;
  logic [4:0]  rflags_q;
  logic [31:0] cnt_good_q, cnt_bad_q;
  logic        stall;
  logic        accept, wr_data, start, in_frame, report;
  logic [15:0] hdr_exp;
  logic [16:0] bytes_sum;
  logic        half;

  // A zero seed would lock the LFSR at zero.
  if (g_seed == 16'h0000) begin : g_zero_seed
    $error("g_seed must be non-zero");
  end

`ifdef WRF_FRAME_CHECKER_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic        stall_q;

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q  <= g_seed;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      stall_q <= snk_cyc_i & (lfsr_q[1:0] == 2'b00);
    end
  end
  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  assign accept  = snk_cyc_i & snk_stb_i & ~stall;
  assign wr_data = accept & snk_we_i & (snk_adr_i == 2'd0);
  assign half    = (snk_sel_i == 2'b10);
  // A cyc rising while DONE is still showing the previous verdict starts the next frame at once.
  assign start    = snk_cyc_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign in_frame = start | (snk_cyc_i & ((state_q == ST_HDR) | (state_q == ST_PAYLOAD)));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    bytes_d   = bytes_q;
    pat_d     = pat_q;
    flags_d   = flags_q;
    report    = 1'b0;
    hdr_exp   = g_ethertype;
    bytes_sum = '0;

    case (state_q)
      ST_IDLE:    ;
      ST_DONE:    state_d = ST_IDLE;
      ST_HDR, ST_PAYLOAD: begin
        if (!snk_cyc_i) begin
          if (state_q == ST_HDR && widx_q == 3'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            report  = 1'b1;
          end
        end
      end
      ST_SKIP:    if (!snk_cyc_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d = ST_HDR;
      widx_d  = 3'd0;
      bytes_d = 16'd0;
      pat_d   = 8'd0;
      flags_d = 5'd0;
    end

    if (in_frame && wr_data) begin
      bytes_sum = {1'b0, bytes_d} + (half ? 17'd1 : 17'd2);
      bytes_d   = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
      if (widx_d != 3'd7) begin
        case (widx_d)
          3'd0:    hdr_exp = cfg_dst_i[47:32];
          3'd1:    hdr_exp = cfg_dst_i[31:16];
          3'd2:    hdr_exp = cfg_dst_i[15:0];
          default: hdr_exp = g_ethertype;
        endcase
        if (widx_d <= 3'd2 && snk_dat_i != hdr_exp) flags_d[F_DST] = 1'b1;
        if (widx_d == 3'd6 && snk_dat_i != hdr_exp) flags_d[F_TYPE] = 1'b1;
        widx_d = widx_d + 3'd1;
        if (widx_d == 3'd7) state_d = ST_PAYLOAD;
      end else if (half) begin
        if (snk_dat_i[15:8] != pat_d) flags_d[F_PAY] = 1'b1;
        pat_d = pat_d + 8'd1;
      end else begin
        if (snk_dat_i != {pat_d, pat_d + 8'd1}) flags_d[F_PAY] = 1'b1;
        pat_d = pat_d + 8'd2;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_SKIP;
      widx_q     <= '0;
      bytes_q    <= '0;
      pat_q      <= '0;
      flags_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      len_q      <= '0;
      rflags_q   <= '0;
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      bytes_q <= bytes_d;
      pat_q   <= pat_d;
      flags_q <= flags_d;
      ack_q   <= accept & snk_we_i;
      err_q   <= accept & ~snk_we_i;
      done_q  <= report;
      if (report) begin
        rflags_q         <= flags_q;
        rflags_q[F_RUNT] <= (state_q == ST_HDR);
        rflags_q[F_OVER] <= (32'(bytes_q) > g_max_len);
        ok_q             <= (flags_q == 5'd0) && (state_q != ST_HDR) && (32'(bytes_q) <= g_max_len);
        len_q            <= bytes_q;
      end
      if (clr_i) begin
        cnt_good_q <= '0;
        cnt_bad_q  <= '0;
      end else if (done_q) begin
        if (ok_q && cnt_good_q != 32'hFFFF_FFFF) cnt_good_q <= cnt_good_q + 32'd1;
        if (!ok_q && cnt_bad_q != 32'hFFFF_FFFF) cnt_bad_q <= cnt_bad_q + 32'd1;
      end
    end
  end

  assign snk_stall_o = stall;
  assign snk_ack_o   = ack_q;
  assign snk_err_o   = err_q;
  assign done_o      = done_q;
  assign ok_o        = ok_q;
  assign len_o       = len_q;
  assign flags_o     = rflags_q;
  assign cnt_good_o  = cnt_good_q;
  assign cnt_bad_o   = cnt_bad_q;

endmodule

// File: tb/tb_wrf_frame_checker.sv
// Directed bench for wrf_frame_checker; inputs driven and outputs sampled on the falling clock edge.
module tb_wrf_frame_checker;

  localparam logic [47:0] DST   = 48'h0050_cafe_babe;
  localparam logic [15:0] ETYPE = 16'h88F7;

  logic        clk = 1'b0;
  logic        rst;
  logic        snk_cyc, snk_stb, snk_we, clr;
  logic [1:0]  snk_adr, snk_sel;
  logic [15:0] snk_dat;
  logic        snk_stall_o, snk_ack_o, snk_err_o, done_o, ok_o;
  logic [15:0] len_o;
  logic [4:0]  flags_o;
  logic [31:0] cnt_good_o, cnt_bad_o;

  int n_pass = 0, n_total = 0;
  int n_acc_wr = 0, n_ack = 0, n_err = 0, n_done = 0, n_overlap = 0;
  int a0, d0;

  always #5 clk = ~clk;

  wrf_frame_checker dut (
    .clk_sys_i(clk), .rst_i(rst),
    .snk_cyc_i(snk_cyc), .snk_stb_i(snk_stb), .snk_we_i(snk_we), .snk_adr_i(snk_adr),
    .snk_dat_i(snk_dat), .snk_sel_i(snk_sel), .snk_stall_o(snk_stall_o),
    .snk_ack_o(snk_ack_o), .snk_err_o(snk_err_o), .cfg_dst_i(DST), .clr_i(clr),
    .done_o(done_o), .ok_o(ok_o), .len_o(len_o), .flags_o(flags_o),
    .cnt_good_o(cnt_good_o), .cnt_bad_o(cnt_bad_o)
  );

  always @(negedge clk) begin
    if (snk_ack_o) n_ack++;
    if (snk_err_o) n_err++;
    if (done_o) n_done++;
    if (snk_ack_o && snk_err_o) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One bus strobe, held through stalls; returns on the falling edge after acceptance.
  task automatic put(input logic [1:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                     input logic we);
    logic stalled;
    bit   taken = 1'b0;
    snk_cyc = 1'b1; snk_stb = 1'b1; snk_we = we; snk_adr = adr; snk_dat = dat; snk_sel = sel;
    for (int n = 0; n < 64 && !taken; n++) begin
      stalled = snk_stall_o;
      @(negedge clk);
      if (!stalled) taken = 1'b1;
    end
    if (!taken) begin
      n_total++;
      $error("FAIL stall_bound: strobe not accepted within 64 cycles, required acceptance");
    end else if (we) begin
      n_acc_wr++;
    end
    snk_stb = 1'b0;
  endtask

  task automatic send_hdr(input logic [47:0] dst, input logic [15:0] typ, input int nw);
    logic [15:0] hw [7];
    hw = '{dst[47:32], dst[31:16], dst[15:0], 16'h1122, 16'h3344, 16'h5566, typ};
    for (int i = 0; i < nw; i++) put(2'd0, hw[i], 2'b11, 1'b1);
  endtask

  task automatic send_pay(input int nbytes, input int bad_word);
    logic [7:0]  p;
    logic [15:0] w;
    for (int i = 0; i < nbytes; i += 2) begin
      p = 8'(i);
      w = {p, p + 8'd1};
      if (i / 2 == bad_word) w = 16'hDEAD;
      if (nbytes - i == 1) put(2'd0, {p, 8'h00}, 2'b10, 1'b1);
      else                 put(2'd0, w, 2'b11, 1'b1);
    end
  endtask

  task automatic end_frame();
    snk_cyc = 1'b0;
    snk_stb = 1'b0;
    @(negedge clk);
  endtask

  // Called on the falling edge right after the one that saw cyc low.
  task automatic check_report(input string tag, input logic ok, input logic [15:0] len,
                              input logic [4:0] flags);
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_ok"}, 32'(ok_o), 32'(ok));
    check({tag, "_len"}, 32'(len_o), 32'(len));
    check({tag, "_flags"}, 32'(flags_o), 32'(flags));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    snk_cyc = 1'b0; snk_stb = 1'b0; snk_we = 1'b0; snk_adr = '0; snk_dat = '0; snk_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ok", 32'(ok_o), 32'd0);
    check("rst_len", 32'(len_o), 32'd0);
    check("rst_flags", 32'(flags_o), 32'd0);
    check("rst_cnt_good", cnt_good_o, 32'd0);
    check("rst_cnt_bad", cnt_bad_o, 32'd0);
    check("rst_ack_err_stall", {29'd0, snk_ack_o, snk_err_o, snk_stall_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send_hdr(DST, ETYPE, 7); send_pay(50, -1); end_frame();
    check_report("good64", 1'b1, 16'd64, 5'b00000);
    check("good64_cnt_good", cnt_good_o, 32'd1);

    send_hdr(DST, ETYPE, 7); send_pay(49, -1); end_frame();
    check_report("good63", 1'b1, 16'd63, 5'b00000);

    send_hdr(DST, 16'hDEAD, 7); send_pay(49, -1); end_frame();
    check_report("badtype63", 1'b0, 16'd63, 5'b00100);
    check("badtype63_cnt_bad", cnt_bad_o, 32'd1);

    send_hdr(DST, ETYPE, 7); send_pay(50, 3); end_frame();
    check_report("badpay", 1'b0, 16'd64, 5'b01000);

    send_hdr(48'h0150_cafe_babe, 16'h0800, 7); send_pay(50, -1); end_frame();
    check_report("baddst_type", 1'b0, 16'd64, 5'b00110);

    send_hdr(DST, ETYPE, 5); end_frame();
    check_report("runt", 1'b0, 16'd10, 5'b00001);

    send_hdr(DST, ETYPE, 7); send_pay(1586, -1); end_frame();
    check_report("oversize", 1'b0, 16'd1600, 5'b10000);
    check("counts_good", cnt_good_o, 32'd2);
    check("counts_bad", cnt_bad_o, 32'd5);

    // OOB write and a read inside a good frame must not disturb it.
    send_hdr(DST, ETYPE, 7);
    put(2'd1, 16'hFFFF, 2'b11, 1'b1);
    put(2'd0, 16'hBEEF, 2'b11, 1'b0);
    check("read_err", 32'(snk_err_o), 32'd1);
    check("read_noack", 32'(snk_ack_o), 32'd0);
    send_pay(50, -1); end_frame();
    check_report("oob_read", 1'b1, 16'd64, 5'b00000);

    d0 = n_done;
    put(2'd1, 16'h1234, 2'b11, 1'b1);
    end_frame();
    repeat (3) @(negedge clk);
    check("nodata_no_done", 32'(n_done - d0), 32'd0);

    // Reset released while cyc stays high: the rest of that frame is acked but never reported.
    send_hdr(DST, ETYPE, 3);
    snk_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cnt_good", cnt_good_o, 32'd0);
    check("midrst_cnt_bad", cnt_bad_o, 32'd0);
    rst = 1'b0;
    a0 = n_ack; d0 = n_done;
    put(2'd0, 16'h1122, 2'b11, 1'b1); put(2'd0, 16'h3344, 2'b11, 1'b1);
    put(2'd0, 16'h5566, 2'b11, 1'b1); put(2'd0, ETYPE, 2'b11, 1'b1);
    send_pay(50, -1); end_frame();
    repeat (3) @(negedge clk);
    check("skip_acks", 32'(n_ack - a0), 32'd29);
    check("skip_no_done", 32'(n_done - d0), 32'd0);
    check("skip_cnt_good", cnt_good_o, 32'd0);
    send_hdr(DST, ETYPE, 7); send_pay(50, -1); end_frame();
    check_report("after_skip", 1'b1, 16'd64, 5'b00000);
    check("after_skip_cnt_good", cnt_good_o, 32'd1);

    d0 = n_done;
    for (int k = 0; k < 4; k++) begin
      send_hdr(DST, ETYPE, 7); send_pay(50, -1);
      snk_cyc = 1'b0; snk_stb = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("b2b_done_pulses", 32'(n_done - d0), 32'd4);
    check("b2b_cnt_good", cnt_good_o, 32'd5);
    check("b2b_cnt_bad", cnt_bad_o, 32'd0);

    // A bad frame whose count is dropped by a clear in its done cycle.
    send_hdr(DST, ETYPE, 5); end_frame();
    clr = 1'b1;
    check("clr_done", 32'(done_o), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("clr_cnt_good", cnt_good_o, 32'd0);
    check("clr_cnt_bad", cnt_bad_o, 32'd0);

`ifdef WRF_FRAME_CHECKER_RAND_STALL_EN
    for (int f = 0; f < 200; f++) begin
      send_hdr(DST, ETYPE, 7);
      send_pay(int'($urandom_range(1, 100)), -1);
      end_frame();
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("rand_cnt_good", cnt_good_o, 32'd200);
    check("rand_cnt_bad", cnt_bad_o, 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("acks_vs_writes", 32'(n_ack), 32'(n_acc_wr));
    check("ack_err_overlap", 32'(n_overlap), 32'd0);
    check("err_count", 32'(n_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wrf_frame_checker.md
Name: wrf_frame_checker

Overview:
- Hardware receive end of the WR fabric (pipelined Wishbone, 16-bit) stream driven by the fabric packet source.
- Accepts whole frames on a fabric sink port and checks them:
  - destination MAC against a configured value;
  - ethertype against a parameter;
  - payload against the sequential-byte pattern (byte i = i mod 256).
- Reports per-frame verdict/length and keeps good/bad counters.
- Instantiated behind a switch output port in scb_top simulation and on-board self-test, replacing a software sink.

Parameters:
- g_ethertype, 16'h88F7, expected ethertype word.
- g_max_len, 1522, maximum frame length in bytes (header + payload); longer = oversize.
- g_seed, 16'hACE1, initial LFSR value (used only with the optional feature).

Ports:
- clk_sys_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- snk_cyc_i  in  1  fabric cycle; one frame per cyc high period
- snk_stb_i  in  1  strobe
- snk_we_i  in  1  write enable
- snk_adr_i  in  2  0=data, 1=OOB, 2=status, 3=user
- snk_dat_i  in  16  data word, big-endian byte order
- snk_sel_i  in  2  byte selects; 2'b10 only on an odd final data byte
- snk_stall_o  out  1  stall
- snk_ack_o  out  1  ack
- snk_err_o  out  1  error
- cfg_dst_i  in  48  expected destination MAC
- clr_i  in  1  synchronous counter clear
- done_o  out  1  one-cycle pulse per completed frame
- ok_o  out  1  verdict of last frame
- len_o  out  16  byte length of last frame (data words only)
- flags_o  out  5  {oversize, payload, type, dst, runt} error flags of last frame
- cnt_good_o  out  32  good-frame counter
- cnt_bad_o  out  32  bad-frame counter

Behaviour:
- Reset values (async, active-high):
  - all outputs 0; counters 0; LFSR = g_seed.
  - State goes to SKIP if snk_cyc_i is high, otherwise IDLE; evaluated the first cycle after reset release.
- Accept condition: snk_cyc_i & snk_stb_i & ~snk_stall_o.
  - Accepted write: snk_ack_o high exactly the next cycle.
  - Accepted read (we=0): snk_err_o high the next cycle instead; data ignored; frame not flagged.
  - ack and err are never high together.
- States:
  - IDLE: a rising snk_cyc_i enters HDR. Clear word index, byte count, flags, payload pattern counter.
  - HDR: data words 0-2 compared to cfg_dst_i[47:32], [31:16], [15:0]; any mismatch sets dst. Words 3-5 (source MAC) are counted but not checked. Word 6 compared to g_ethertype; mismatch sets type. After word 6 go to PAYLOAD.
  - PAYLOAD: each data word must equal {p, p+1} (8-bit wrap), where p = payload byte index mod 256.
    - sel=2'b10 checks only the high byte and adds 1 byte; otherwise adds 2.
    - Any mismatch sets payload; checking continues, flag is sticky.
  - Any state, adr=1/2/3 words: acked, not counted, not checked.
  - Falling snk_cyc_i in HDR or PAYLOAD goes to DONE:
    - runt if fewer than 7 header words (<14 bytes);
    - oversize if byte count > g_max_len. The byte counter saturates at 16'hFFFF.
  - Falling snk_cyc_i in IDLE (no data words): no report, stay IDLE.
  - DONE (1 cycle): drive done_o=1 and update ok_o/len_o/flags_o.
    - ok_o = (flags==0).
    - Increment cnt_good_o or cnt_bad_o; counters saturate at 32'hFFFFFFFF.
    - Return to IDLE.
    - A new cyc rising in the DONE cycle is captured as the start of the next frame; no words are lost.
  - SKIP: ignore everything (writes still acked) until snk_cyc_i low, then IDLE. Handles reset released mid-frame; the partial frame is never reported.
- Latency: done_o is 1 cycle after the cycle where snk_cyc_i is sampled low.
- clr_i zeroes both counters. If clr_i coincides with done_o, clear wins (count of that frame lost).
- Without the optional feature, snk_stall_o is constantly 0.

Optional Feature:
- Macro: WRF_FRAME_CHECKER_RAND_STALL_EN.
- Defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every cycle.
  - snk_stall_o = snk_cyc_i & (lfsr[1:0]==2'b00), registered, roughly 25% stall.
  - Stalled strobes are not accepted and not acked.
- Undefined: no LFSR logic; snk_stall_o tied 0.

Test Plan:
- 64-byte frame, dst=00:50:ca:fe:ba:be = cfg_dst_i, type 88F7, payload 00..31 -> done_o 1 cycle after cyc falls; ok_o=1, len_o=64, flags_o=0, cnt_good_o=1.
- 63-byte frame (last word sel=2'b10, high byte 0x30) -> ok_o=1, len_o=63; then one word corrupted to 16'hDEAD -> flags_o=5'b00100, cnt_bad_o=1.
- Frame with dst byte 0 = 0x01 and ethertype 0x0800 -> flags_o=5'b00110.
- 5-word frame -> flags_o=5'b00001 (runt), len_o=10. Separately, 1600-byte frame with g_max_len=1522 -> flags_o=5'b10000.
- rst_i pulsed mid-frame while cyc stays high:
  - no done_o for that frame; remaining writes acked;
  - next full good frame gives cnt_good_o=1;
  - 4 back-to-back frames with 1-cycle cyc gap give 4 done_o pulses.
- With WRF_FRAME_CHECKER_RAND_STALL_EN, 200 random-length good frames -> cnt_good_o=200, cnt_bad_o=0, acks == accepted strobes, no ack in any stall cycle. Also clr_i coinciding with done_o -> both counters 0.
